// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller_if
//  Description : Request/response bundle between the MEM stage (master) and
//                the SRAM controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_controller_if;
   logic        wr_en;   // write request, held until ready
   logic        rd_en;   // read request, held until ready
   logic [31:0] addr;    // word-aligned byte address
   logic [31:0] wdata;   // write data
   logic [31:0] rdata;   // read data, valid in the completion cycle
   logic        ready;   // high = idle or access completing this cycle

   modport master (
      output wr_en, rd_en, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata,
      output rdata, ready
   );
endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : Completes 32-bit word requests from the MEM stage as two
//                16-bit accesses (low half, then high half) on an external
//                asynchronous SRAM. ready stays low until the access is done,
//                which freezes the pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 2,        // cycles per 16-bit half (1..15)
   parameter logic [31:0] BASE_ADDR   = 32'd1024  // byte address of SRAM word 0
) (
   input  wire logic          clk,
   input  wire logic          rst,
   sram_controller_if.slave   bus,
   inout  wire logic [15:0]   SRAM_DQ,
   output logic      [17:0]   SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   // State encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR_LO = 3'd1;
   localparam logic [2:0] S_WR_HI = 3'd2;
   localparam logic [2:0] S_RD_LO = 3'd3;
   localparam logic [2:0] S_RD_HI = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Counter value reached on the final cycle of a half
   localparam logic [3:0] C_LAST_CNT = 4'(WAIT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;

   logic [16:0] w_widx;
   logic        w_cnt_last;
   logic        w_ready;
   logic        w_dq_oe;
   logic [15:0] w_dq_out;

   // Word index into the SRAM; the subtraction wraps and is then truncated,
   // so addresses below BASE_ADDR alias high in the array.
   assign w_widx     = 17'((bus.addr - BASE_ADDR) >> 2);
   assign w_cnt_last = (cnt_q == C_LAST_CNT);

   // Byte lanes, chip enable and output enable are permanently active;
   // WE_N alone decides between read and write.
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

   // The data bus is only driven during write halves.
   assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;

   assign bus.ready = w_ready;
   assign bus.rdata = rdata_q;

   // State, wait counter and read-data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and wait-counter sequencing
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            // Write takes priority when both requests are raised.
            if (bus.wr_en) begin
               state_d = S_WR_LO;
            end else if (bus.rd_en) begin
               state_d = S_RD_LO;
            end
         end
         S_WR_LO: begin
            if (w_cnt_last) begin
               state_d = S_WR_HI;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         S_WR_HI: begin
            if (w_cnt_last) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         S_RD_LO: begin
            if (w_cnt_last) begin
               state_d = S_RD_HI;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         S_RD_HI: begin
            if (w_cnt_last) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d   = cnt_q + 4'd1;
            end
         end
         S_DONE: begin
            // The request still visible here is the one just finished.
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Read data capture: each half is sampled on its final bus cycle
   always_comb begin
      rdata_d = rdata_q;
      if (state_q == S_RD_LO && w_cnt_last) begin
         rdata_d[15:0]  = SRAM_DQ;
      end
      if (state_q == S_RD_HI && w_cnt_last) begin
         rdata_d[31:16] = SRAM_DQ;
      end
   end

   // SRAM pin and handshake outputs decoded from the current state
   always_comb begin
      w_ready   = 1'b0;
      w_dq_oe   = 1'b0;
      w_dq_out  = 16'd0;
      SRAM_WE_N = 1'b1;
      SRAM_ADDR = 18'd0;
      case (state_q)
         S_IDLE: begin
            w_ready = ~bus.wr_en & ~bus.rd_en;
         end
         S_WR_LO: begin
            SRAM_WE_N = 1'b0;
            SRAM_ADDR = {w_widx, 1'b0};
            w_dq_oe   = 1'b1;
            w_dq_out  = bus.wdata[15:0];
         end
         S_WR_HI: begin
            SRAM_WE_N = 1'b0;
            SRAM_ADDR = {w_widx, 1'b1};
            w_dq_oe   = 1'b1;
            w_dq_out  = bus.wdata[31:16];
         end
         S_RD_LO: begin
            SRAM_ADDR = {w_widx, 1'b0};
         end
         S_RD_HI: begin
            SRAM_ADDR = {w_widx, 1'b1};
         end
         S_DONE: begin
            w_ready = 1'b1;
         end
         default: begin
            w_ready = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
